// File: rtl/robo_nav_ctrl.sv
// Wall-following navigation controller: decodes head/left/under/barrier sensors into
// advance/rotate/U-turn/debris-clear actions, with spin/jam detection and a coded sticky fault.
module robo_nav_ctrl #(
  parameter int ROT_CYCLES      = 2,
  parameter int UTURN_CYCLES    = 4,
  parameter int CLEAR_CYCLES    = 3,
  parameter int MAX_TURNS       = 4,
  parameter int MAX_CLEAR_RETRY = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               stop,
  input  logic                               clear_fault,
  input  logic                               head,
  input  logic                               left,
  input  logic                               under,
  input  logic                               barrier,
  output logic                               avancar,
  output logic                               girar,
  output logic                               recolher_entulho,
  output logic [2:0]                         state,
  output logic                               halted,
  output logic [2:0]                         fault,
  output logic [$clog2(MAX_TURNS+1)-1:0]     turn_count
);

  localparam int MAX_DUR = (ROT_CYCLES > UTURN_CYCLES)
                           ? ((ROT_CYCLES > CLEAR_CYCLES) ? ROT_CYCLES : CLEAR_CYCLES)
                           : ((UTURN_CYCLES > CLEAR_CYCLES) ? UTURN_CYCLES : CLEAR_CYCLES);
  localparam int TW  = $clog2(MAX_DUR) + 1;
  localparam int TCW = $clog2(MAX_TURNS + 1);
  localparam int CCW = $clog2(MAX_CLEAR_RETRY + 1) + 1;

  localparam logic [2:0] F_NONE  = 3'd0;
  localparam logic [2:0] F_HOLE  = 3'd1;
  localparam logic [2:0] F_BLOCK = 3'd2;
  localparam logic [2:0] F_SPIN  = 3'd3;
  localparam logic [2:0] F_JAM   = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADVANCE = 3'd1,
    ROTATE  = 3'd2,
    CLEAR   = 3'd3,
    UTURN   = 3'd4,
    HALT    = 3'd5
  } state_t;

  state_t         state_q, state_next;
  logic [TW-1:0]  timer_q, timer_next;
  logic [TCW-1:0] turn_q, turn_next;
  logic [CCW-1:0] clear_q, clear_next;
  logic [2:0]     fault_q, fault_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      turn_q  <= '0;
      clear_q <= '0;
      fault_q <= F_NONE;
    end else begin
      state_q <= state_next;
      timer_q <= timer_next;
      turn_q  <= turn_next;
      clear_q <= clear_next;
      fault_q <= fault_next;
    end
  end

  // Decision D is evaluated only when the current state is ready to hand over, then
  // filtered through the turn-limit and clear-retry guards before being committed.
  always_comb begin
    logic   apply_d;
    state_t dec_state;
    logic [2:0] dec_fault;

    state_next = state_q;
    timer_next = timer_q;
    turn_next  = turn_q;
    clear_next = clear_q;
    fault_next = fault_q;
    apply_d    = 1'b0;
    dec_state  = IDLE;
    dec_fault  = F_NONE;

    case (state_q)
      IDLE:    apply_d = start;
      ADVANCE: apply_d = 1'b1;
      ROTATE, UTURN, CLEAR: begin
        if (timer_q == '0) apply_d = 1'b1;
        else               timer_next = timer_q - TW'(1);
      end
      HALT: begin
        if (clear_fault) begin
          state_next = IDLE;
          fault_next = F_NONE;
          timer_next = '0;
          turn_next  = '0;
          clear_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (under)               begin dec_state = HALT; dec_fault = F_HOLE;  end
    else if (head && barrier) begin dec_state = HALT; dec_fault = F_BLOCK; end
    else if (barrier)        dec_state = CLEAR;
    else if (!head)          dec_state = ADVANCE;
    else if (!left)          dec_state = ROTATE;
    else                     dec_state = UTURN;

    if (apply_d) begin
      state_next = dec_state;
      fault_next = F_NONE;
      timer_next = '0;
      case (dec_state)
        HALT: fault_next = dec_fault;
        ADVANCE: turn_next = '0;
        ROTATE, UTURN: begin
          if (turn_q == TCW'(MAX_TURNS)) begin
            state_next = HALT;
            fault_next = F_SPIN;
          end else begin
            turn_next  = turn_q + TCW'(1);
            timer_next = (dec_state == ROTATE) ? TW'(ROT_CYCLES - 1) : TW'(UTURN_CYCLES - 1);
          end
        end
        CLEAR: begin
          if (state_q != CLEAR) begin
            clear_next = '0;
            timer_next = TW'(CLEAR_CYCLES - 1);
          end else if (clear_q == CCW'(MAX_CLEAR_RETRY)) begin
            state_next = HALT;
            fault_next = F_JAM;
          end else begin
            clear_next = clear_q + CCW'(1);
            timer_next = TW'(CLEAR_CYCLES - 1);
          end
        end
        default: ;
      endcase
    end

    if (stop && state_q != HALT) begin
      state_next = IDLE;
      fault_next = F_NONE;
      timer_next = '0;
      turn_next  = '0;
      clear_next = '0;
    end
  end

  assign avancar          = (state_q == ADVANCE);
  assign girar            = (state_q == ROTATE) || (state_q == UTURN);
  assign recolher_entulho = (state_q == CLEAR);
  assign halted           = (state_q == HALT);
  assign state            = state_q;
  assign fault            = fault_q;
  assign turn_count       = turn_q;

endmodule
